// File: rtl/sensor_frame_rx.sv
// UART (8N1) sensor frame receiver: decodes A5/TYPE/DATA/CSUM frames into the
// controller's geo/gps/QR inputs and keeps a link-alive enable.
module sensor_frame_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int GAP_BITS     = 20,
    parameter int LINK_TIMEOUT = 50_000_000
) (
    input  logic       PWM,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] geo_out,
    output logic [7:0] gps_out,
    output logic       QR_out,
    output logic       EN_out,
    output logic       frame_ok,
    output logic       frame_err
);

    localparam int CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
    localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
    localparam int LINK_W    = $clog2(LINK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0]  GAP_M1   = GAP_W'(GAP_LIMIT - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(GAP_LIMIT);
    localparam logic [LINK_W-1:0] LINK_MAX = LINK_W'(LINK_TIMEOUT);
    localparam logic [7:0]        HEADER   = 8'hA5;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {P_IDLE, P_TYPE, P_DATA, P_CSUM} p_state_t;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             fall_s, start_det_s, stop_smp_s, byte_valid_s, byte_err_s;

    p_state_t         p_state_q, p_state_d;
    logic [7:0]       type_q, type_d, data_q, data_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             timeout_s;
    logic [7:0]       geo_q, geo_d, gps_q, gps_d;
    logic             qr_q, qr_d, en_q, en_d;
    logic             frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
    logic [LINK_W-1:0] link_cnt_q, link_cnt_d;

    // RX synchronizer and previous-sample tracker; reset to the idle-high level
    always_ff @(posedge PWM) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign fall_s = rx_prev_q & ~rx_sync_q;

    // Byte receiver state register
    always_ff @(posedge PWM) begin
        if (RST) begin
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Byte receiver next state: mid-bit sampling counted from the detected start edge
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            R_IDLE: begin
                rx_cnt_d = '0;
                if (fall_s) begin
                    rx_state_d = R_START;
                end else begin
                    rx_state_d = R_IDLE;
                end
            end
            R_START: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
                end else begin
                    rx_state_d = R_START;
                end
            end
            R_DATA: begin
                if (rx_cnt_q == BIT_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    rx_state_d = (rx_bit_q == 3'd7) ? R_STOP : R_DATA;
                end else begin
                    rx_state_d = R_DATA;
                end
            end
            R_STOP: begin
                if (rx_cnt_q == BIT_M1) begin
                    rx_cnt_d   = '0;
                    rx_state_d = R_IDLE;
                end else begin
                    rx_state_d = R_STOP;
                end
            end
            default: begin
                rx_cnt_d   = '0;
                rx_state_d = R_IDLE;
            end
        endcase
    end

    // Byte receiver outputs: start detection and stop-bit verdict
    always_comb begin
        start_det_s = 1'b0;
        stop_smp_s  = 1'b0;
        case (rx_state_q)
            R_IDLE:  start_det_s = fall_s;
            R_STOP:  stop_smp_s  = (rx_cnt_q == BIT_M1);
            default: stop_smp_s  = 1'b0;
        endcase
        byte_valid_s = stop_smp_s & rx_sync_q;
        byte_err_s   = stop_smp_s & ~rx_sync_q;
    end

    // Inter-byte gap counter, restarted by every start edge while a frame is open
    always_comb begin
        if (p_state_q == P_IDLE || start_det_s) begin
            gap_cnt_d = '0;
        end else if (gap_cnt_q != GAP_MAX) begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end else begin
            gap_cnt_d = gap_cnt_q;
        end
        timeout_s = (p_state_q != P_IDLE) && (gap_cnt_q == GAP_M1) && !start_det_s;
    end

    // Parser state register
    always_ff @(posedge PWM) begin
        if (RST) begin
            p_state_q <= P_IDLE;
            type_q    <= 8'h00;
            data_q    <= 8'h00;
            gap_cnt_q <= '0;
        end else begin
            p_state_q <= p_state_d;
            type_q    <= type_d;
            data_q    <= data_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Parser next state: bytes are positional, any error falls back to P_IDLE
    always_comb begin
        p_state_d = p_state_q;
        case (p_state_q)
            P_IDLE: begin
                if (byte_valid_s && rx_shift_q == HEADER) begin
                    p_state_d = P_TYPE;
                end else begin
                    p_state_d = P_IDLE;
                end
            end
            P_TYPE: begin
                if (byte_valid_s) begin
                    p_state_d = P_DATA;
                end else if (byte_err_s || timeout_s) begin
                    p_state_d = P_IDLE;
                end else begin
                    p_state_d = P_TYPE;
                end
            end
            P_DATA: begin
                if (byte_valid_s) begin
                    p_state_d = P_CSUM;
                end else if (byte_err_s || timeout_s) begin
                    p_state_d = P_IDLE;
                end else begin
                    p_state_d = P_DATA;
                end
            end
            P_CSUM: begin
                if (byte_valid_s || byte_err_s || timeout_s) begin
                    p_state_d = P_IDLE;
                end else begin
                    p_state_d = P_CSUM;
                end
            end
            default: p_state_d = P_IDLE;
        endcase
    end

    // Parser outputs: field capture, frame verdict and output-register loads
    always_comb begin
        type_d      = type_q;
        data_d      = data_q;
        geo_d       = geo_q;
        gps_d       = gps_q;
        qr_d        = qr_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        case (p_state_q)
            P_IDLE: begin
                frame_err_d = byte_err_s;
            end
            P_TYPE: begin
                if (byte_valid_s) begin
                    type_d = rx_shift_q;
                end else begin
                    frame_err_d = byte_err_s | timeout_s;
                end
            end
            P_DATA: begin
                if (byte_valid_s) begin
                    data_d = rx_shift_q;
                end else begin
                    frame_err_d = byte_err_s | timeout_s;
                end
            end
            P_CSUM: begin
                if (byte_valid_s && rx_shift_q == (type_q ^ data_q)) begin
                    frame_ok_d = 1'b1;
                    case (type_q)
                        8'h01:   geo_d = data_q;
                        8'h02:   gps_d = data_q;
                        8'h03:   qr_d  = data_q[0];
                        default: begin
                            frame_ok_d  = 1'b0;
                            frame_err_d = 1'b1;
                        end
                    endcase
                end else if (byte_valid_s) begin
                    frame_err_d = 1'b1;
                end else begin
                    frame_err_d = byte_err_s | timeout_s;
                end
            end
            default: frame_err_d = 1'b0;
        endcase
    end

    // Link-alive counter: cleared by each accepted frame, saturates at the timeout
    always_comb begin
        if (frame_ok_d) begin
            link_cnt_d = '0;
            en_d       = 1'b1;
        end else if (link_cnt_q != LINK_MAX) begin
            link_cnt_d = link_cnt_q + LINK_W'(1);
            en_d       = (link_cnt_q + LINK_W'(1) == LINK_MAX) ? 1'b0 : en_q;
        end else begin
            link_cnt_d = link_cnt_q;
            en_d       = 1'b0;
        end
    end

    // Registered outputs
    always_ff @(posedge PWM) begin
        if (RST) begin
            geo_q       <= 8'h00;
            gps_q       <= 8'h00;
            qr_q        <= 1'b0;
            en_q        <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            link_cnt_q  <= '0;
        end else begin
            geo_q       <= geo_d;
            gps_q       <= gps_d;
            qr_q        <= qr_d;
            en_q        <= en_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            link_cnt_q  <= link_cnt_d;
        end
    end

    assign geo_out   = geo_q;
    assign gps_out   = gps_q;
    assign QR_out    = qr_q;
    assign EN_out    = en_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sensor_frame_rx.sv
// Directed bench for sensor_frame_rx with 4 clocks per bit and a 400-cycle link timeout.
module tb_sensor_frame_rx;

    localparam int CPB = 4;

    logic       PWM = 1'b0;
    logic       RST;
    logic       RX;
    logic [7:0] geo_out, gps_out;
    logic       QR_out, EN_out, frame_ok, frame_err;

    int checks = 0;
    int errors = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int ok0, err0, n, cyc;

    sensor_frame_rx #(
        .CLKS_PER_BIT (CPB),
        .GAP_BITS     (20),
        .LINK_TIMEOUT (400)
    ) dut (
        .PWM       (PWM),
        .RST       (RST),
        .RX        (RX),
        .geo_out   (geo_out),
        .gps_out   (gps_out),
        .QR_out    (QR_out),
        .EN_out    (EN_out),
        .frame_ok  (frame_ok),
        .frame_err (frame_err)
    );

    always #5 PWM = ~PWM;

    // Pulse counters
    always @(posedge PWM) begin
        if (frame_ok)              ok_cnt++;
        if (frame_err)             err_cnt++;
        if (frame_ok && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int cycles);
        RX = 1'b1;
        repeat (cycles) @(negedge PWM);
    endtask

    task automatic hold_bit(input logic v);
        RX = v;
        repeat (CPB) @(negedge PWM);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop);
        RX = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] t, input logic [7:0] d, input logic [7:0] c);
        send_byte(8'hA5, 1'b1);
        send_byte(t, 1'b1);
        send_byte(d, 1'b1);
        send_byte(c, 1'b1);
        idle(6);
    endtask

    initial begin
        RST = 1'b1;
        RX  = 1'b1;
        repeat (5) @(negedge PWM);
        check("rst_geo", 32'(geo_out), 32'h00);
        check("rst_gps", 32'(gps_out), 32'h00);
        check("rst_qr", 32'(QR_out), 32'h0);
        check("rst_en", 32'(EN_out), 32'h0);
        check("rst_ok", 32'(frame_ok), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        RST = 1'b0;
        idle(5);

        // Geo frame
        ok0 = ok_cnt; err0 = err_cnt;
        send_frame(8'h01, 8'h46, 8'h47);
        check("geo_val", 32'(geo_out), 32'h46);
        check("geo_ok_pulses", 32'(ok_cnt - ok0), 32'd1);
        check("geo_en", 32'(EN_out), 32'h1);
        check("geo_gps_untouched", 32'(gps_out), 32'h00);

        // GPS then QR frames
        ok0 = ok_cnt; err0 = err_cnt;
        send_frame(8'h02, 8'hC6, 8'hC4);
        send_frame(8'h03, 8'h01, 8'h02);
        check("gps_val", 32'(gps_out), 32'hC6);
        check("qr_val", 32'(QR_out), 32'h1);
        check("gps_qr_ok_pulses", 32'(ok_cnt - ok0), 32'd2);
        check("gps_qr_no_err", 32'(err_cnt - err0), 32'd0);

        // Bad checksum, then unsupported type, then good frames
        ok0 = ok_cnt; err0 = err_cnt;
        send_frame(8'h01, 8'h46, 8'h00);
        check("badcs_err", 32'(err_cnt - err0), 32'd1);
        check("badcs_geo_hold", 32'(geo_out), 32'h46);
        send_frame(8'h04, 8'h10, 8'h14);
        check("badtype_err", 32'(err_cnt - err0), 32'd2);
        check("bad_no_ok", 32'(ok_cnt - ok0), 32'd0);
        send_frame(8'h01, 8'hC6, 8'hC7);
        check("geo_c6", 32'(geo_out), 32'hC6);
        send_frame(8'h01, 8'hA5, 8'hA4);
        check("geo_a5_positional", 32'(geo_out), 32'hA5);

        // Inter-byte gap timeout and recovery
        ok0 = ok_cnt; err0 = err_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        idle(100);
        check("gap_err", 32'(err_cnt - err0), 32'd1);
        send_frame(8'h02, 8'h11, 8'h13);
        check("gap_recover_gps", 32'(gps_out), 32'h11);
        check("gap_recover_ok", 32'(ok_cnt - ok0), 32'd1);

        // One-cycle glitch, then a byte with a low stop bit
        ok0 = ok_cnt; err0 = err_cnt;
        RX = 1'b0;
        @(negedge PWM);
        idle(20);
        check("glitch_no_err", 32'(err_cnt - err0), 32'd0);
        check("glitch_no_ok", 32'(ok_cnt - ok0), 32'd0);
        send_byte(8'h3C, 1'b0);
        idle(6);
        check("stop_low_err", 32'(err_cnt - err0), 32'd1);
        check("stop_low_gps_hold", 32'(gps_out), 32'h11);

        // Link timeout measured from the frame_ok pulse
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h32, 1'b1);
        n = 0;
        while (!frame_ok && n < 200) begin
            @(negedge PWM);
            n++;
        end
        check("link_ok_seen", 32'(frame_ok), 32'h1);
        check("link_en_high", 32'(EN_out), 32'h1);
        cyc = 0;
        while (EN_out && cyc < 1000) begin
            @(negedge PWM);
            cyc++;
        end
        check("link_en_fall_cycles", 32'(cyc), 32'd400);
        check("link_geo_hold", 32'(geo_out), 32'h33);
        check("link_qr_hold", 32'(QR_out), 32'h1);

        // Reset in the middle of a frame
        ok0 = ok_cnt; err0 = err_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        RX = 1'b0;
        repeat (10) @(negedge PWM);
        RST = 1'b1;
        RX  = 1'b1;
        repeat (3) @(negedge PWM);
        check("mid_rst_geo", 32'(geo_out), 32'h00);
        check("mid_rst_gps", 32'(gps_out), 32'h00);
        check("mid_rst_qr", 32'(QR_out), 32'h0);
        check("mid_rst_en", 32'(EN_out), 32'h0);
        RST = 1'b0;
        idle(100);
        check("mid_rst_no_err", 32'(err_cnt - err0), 32'd0);
        check("mid_rst_no_ok", 32'(ok_cnt - ok0), 32'd0);
        send_frame(8'h02, 8'h7E, 8'h7C);
        check("post_rst_gps", 32'(gps_out), 32'h7E);
        check("post_rst_en", 32'(EN_out), 32'h1);

        check("ok_err_exclusive", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_frame_rx.md
SENSOR_FRAME_RX -- requirements
Module: sensor_frame_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (115200 baud at 50 MHz).
REQ-002 Parameter GAP_BITS, default 20, inter-byte timeout in bit times while a frame is in progress.
REQ-003 Parameter LINK_TIMEOUT, default 50_000_000, clock cycles without a valid frame before EN_out drops.
REQ-004 PWM  in  1  system clock; all logic on its rising edge, single clock domain.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 RX  in  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-007 geo_out  out  8  latest valid direction-angle byte; feeds the controller geo_in.
REQ-008 gps_out  out  8  latest valid latitude byte; feeds the controller gps_in.
REQ-009 QR_out  out  1  latest QR-present flag; feeds the controller QR_in.
REQ-010 EN_out  out  1  link-alive enable; feeds the controller EN.
REQ-011 frame_ok  out  1  one-cycle pulse per accepted frame.
REQ-012 frame_err  out  1  one-cycle pulse per rejected frame or byte.

Function
REQ-013 RX SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-014 Byte receiver: a high-to-low transition in idle starts a byte; the start bit is resampled at CLKS_PER_BIT/2; if it is high, the receiver returns to idle with no error.
REQ-015 Data bits SHALL be sampled at mid-bit, CLKS_PER_BIT apart. The stop bit SHALL be sampled one bit after the last data bit.
REQ-016 A stop bit sampled low SHALL discard the byte, pulse frame_err, and return the parser to P_IDLE.
REQ-017 Frame format: 0xA5 header, TYPE, DATA, CSUM, where CSUM = TYPE XOR DATA.
REQ-018 Parser FSM states are P_IDLE, P_TYPE, P_DATA, and P_CSUM.
REQ-019 In P_IDLE, byte 0xA5 moves the parser to P_TYPE. Any other byte is ignored silently.
REQ-020 P_TYPE stores TYPE and moves to P_DATA. P_DATA stores DATA and moves to P_CSUM. Bytes are positional with no resync, so 0xA5 in these states is ordinary data.
REQ-021 In P_CSUM, a matching CSUM with TYPE 0x01 loads geo_out, 0x02 loads gps_out, and 0x03 loads QR_out from DATA[0].
REQ-022 On acceptance, the register load and the frame_ok pulse SHALL occur in the clock cycle after the CSUM stop-bit sample. The parser then returns to P_IDLE.
REQ-023 A CSUM mismatch or a TYPE outside 0x01..0x03 SHALL pulse frame_err, update no outputs, and return the parser to P_IDLE.
REQ-024 In P_TYPE, P_DATA, or P_CSUM, a gap of GAP_BITS*CLKS_PER_BIT cycles with no start bit SHALL pulse frame_err and return the parser to P_IDLE. The gap counter restarts at each detected start bit.
REQ-025 frame_ok and frame_err SHALL never assert in the same cycle.
REQ-026 EN_out SHALL go high in the same cycle as any frame_ok, and the link counter SHALL clear to 0 on each frame_ok.
REQ-027 The link counter SHALL increment every cycle and saturate. When it reaches LINK_TIMEOUT, EN_out SHALL drop to 0; geo_out, gps_out, and QR_out hold their values.
REQ-028 Output registers SHALL hold their values between accepted frames.

Reset
REQ-029 While RST is high: geo_out=0x00, gps_out=0x00, QR_out=0, EN_out=0, frame_ok=0, frame_err=0, parser in P_IDLE, receiver idle, all counters 0.
REQ-030 RST asserted mid-byte or mid-frame SHALL abandon the partial data without a frame_err pulse. After RST is released, the first accepted byte must have its start edge after the release.

Verification (CLKS_PER_BIT=4, GAP_BITS=20, LINK_TIMEOUT=400)
REQ-031 Send A5 01 46 47 -> geo_out=0x46, one frame_ok, EN_out=1, gps_out still 0x00.
REQ-032 Send A5 02 C6 C4, then A5 03 01 02 -> gps_out=0xC6, QR_out=1, two frame_ok pulses, no frame_err.
REQ-033 Send A5 01 46 00 (bad CSUM) -> one frame_err, geo_out unchanged. Then send A5 01 C6 C7 -> geo_out=0xC6.
REQ-034 Send A5 02 then idle for 100 cycles -> frame_err at the timeout. A following valid frame is accepted.
REQ-035 Send a 1-cycle low glitch on RX -> no byte received, no pulses. Send a byte with stop bit 0 -> frame_err.
REQ-036 Send a valid frame, then no traffic -> EN_out falls exactly 400 cycles after frame_ok. Assert RST mid-frame -> all outputs return to their reset values, no frame_err.
